// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, fetches one instruction at a time and selects the next PC on retire
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_en,
    input  logic        br_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign,
    output logic [31:0] trap_epc
);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_EXEC} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] trap_epc_q, trap_epc_d;
    logic [31:0] target;
    logic        do_retire;

    // Request is decoded from state so an asserted reset drops it without waiting for a clock
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign misalign    = misalign_q;
    assign trap_epc    = trap_epc_q;

    // Next-PC selection (jalr > jal > taken branch > pc+4) and FSM sequencing
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = 1'b0;
        trap_epc_d    = trap_epc_q;
        target        = jalr ? ((rs1 + imm) & ~32'h1) :
                        (jal || (br_en && br_taken)) ? (pc_q + imm) : pc_plus4;
        do_retire     = (state_q == S_EXEC) && retire;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: state_d = imem_ready ? S_WAIT : S_FETCH;
            S_WAIT: begin
                if (imem_valid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_EXEC;
                end
            end
            default: begin
                if (do_retire) begin
                    misalign_d    = target[1];
                    trap_epc_d    = target[1] ? pc_q : trap_epc_q;
                    pc_d          = target[1] ? TRAP_VECTOR : target;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            trap_epc_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
            trap_epc_q    <= trap_epc_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed tests of fetch handshake, next-PC selection, traps and reset
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_en = 1'b0, br_taken = 1'b0, jal = 1'b0, jalr = 1'b0, retire = 1'b0;
    logic [31:0] imm = 32'h0, rs1 = 32'h0;
    logic        imem_req, imem_ready = 1'b0, imem_valid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic [31:0] instr, pc, pc_plus4, trap_epc;
    logic        instr_valid, misalign;
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .br_en(br_en), .br_taken(br_taken), .jal(jal), .jalr(jalr),
        .imm(imm), .rs1(rs1), .retire(retire), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .misalign(misalign), .trap_epc(trap_epc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] word);
        int n = 0;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            chk_cnt++;
            $display("FAIL fetch_timeout: imem_req=%b required 1", imem_req);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = word;
        tick();
        imem_valid = 1'b0;
    endtask

    task automatic do_retire(input logic j, input logic jr, input logic be, input logic bt,
                             input logic [31:0] im, input logic [31:0] r1);
        jal = j; jalr = jr; br_en = be; br_taken = bt; imm = im; rs1 = r1; retire = 1'b1;
        tick();
        jal = 0; jalr = 0; br_en = 0; br_taken = 0; imm = 0; rs1 = 0; retire = 0;
    endtask

    task automatic test_reset();
        #2;
        chk_cnt++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0 || misalign !== 1'b0 || trap_epc !== 32'h0 || instr !== 32'h0)
            $display("FAIL reset_state: req=%b pc=%h iv=%b mis=%b epc=%h instr=%h required 0", imem_req, pc, instr_valid, misalign, trap_epc, instr);
        else pass_cnt++;
        imem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0)
            $display("FAIL boot_fetch: req=%b addr=%h iv=%b required 1/0/0", imem_req, imem_addr, instr_valid);
        else pass_cnt++;
        tick();
        imem_ready = 1'b0;
        chk_cnt++; if (imem_req !== 1'b0)
            $display("FAIL wait_req: got %b required 0", imem_req);
        else pass_cnt++;
        imem_valid = 1'b1;
        imem_rdata = 32'h0000_0013;
        tick();
        imem_valid = 1'b0;
        chk_cnt++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0013)
            $display("FAIL first_instr: iv=%b instr=%h required 1/00000013", instr_valid, instr);
        else pass_cnt++;
        do_retire(0, 0, 0, 0, 32'h0, 32'h0);
        chk_cnt++; if (pc !== 32'h4 || imem_addr !== 32'h4 || imem_req !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL plain_retire: pc=%h addr=%h req=%b iv=%b required 4/4/1/0", pc, imem_addr, imem_req, instr_valid);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        do_fetch(32'h1);
        do_retire(1, 0, 0, 0, 32'h3C, 32'h0);
        chk_cnt++; if (pc !== 32'h40) $display("FAIL jal_fwd: pc=%h required 00000040", pc); else pass_cnt++;
        do_fetch(32'h2);
        do_retire(0, 0, 1, 1, 32'hFFFF_FFF0, 32'h0);
        chk_cnt++; if (pc !== 32'h30) $display("FAIL br_taken: pc=%h required 00000030", pc); else pass_cnt++;
        do_fetch(32'h3);
        do_retire(1, 0, 0, 0, 32'h10, 32'h0);
        do_fetch(32'h4);
        do_retire(0, 0, 1, 0, 32'hFFFF_FFF0, 32'h0);
        chk_cnt++; if (pc !== 32'h44) $display("FAIL br_not_taken: pc=%h required 00000044", pc); else pass_cnt++;
        do_fetch(32'h5);
        do_retire(0, 0, 0, 1, 32'h100, 32'h0);
        chk_cnt++; if (pc !== 32'h48) $display("FAIL taken_no_en: pc=%h required 00000048", pc); else pass_cnt++;
        do_fetch(32'h6);
        do_retire(0, 0, 1, 0, 32'h2, 32'h0);
        chk_cnt++; if (pc !== 32'h4C || misalign !== 1'b0)
            $display("FAIL nt_no_trap: pc=%h mis=%b required 0000004c/0", pc, misalign);
        else pass_cnt++;
    endtask

    task automatic test_jalr_trap();
        do_fetch(32'h7);
        do_retire(1, 0, 0, 0, 32'hFFFF_FFF4, 32'h0);
        chk_cnt++; if (pc !== 32'h40) $display("FAIL jal_back: pc=%h required 00000040", pc); else pass_cnt++;
        do_fetch(32'h8);
        do_retire(0, 1, 0, 0, 32'h2, 32'h1001);
        chk_cnt++; if (misalign !== 1'b1 || trap_epc !== 32'h40 || pc !== 32'h100)
            $display("FAIL jalr_trap: mis=%b epc=%h pc=%h required 1/00000040/00000100", misalign, trap_epc, pc);
        else pass_cnt++;
        tick();
        chk_cnt++; if (misalign !== 1'b0) $display("FAIL trap_pulse: mis=%b required 0", misalign); else pass_cnt++;
        do_fetch(32'h9);
        do_retire(0, 1, 0, 0, 32'h3, 32'h1001);
        chk_cnt++; if (pc !== 32'h1004 || misalign !== 1'b0 || trap_epc !== 32'h40)
            $display("FAIL jalr_ok: pc=%h mis=%b epc=%h required 00001004/0/00000040", pc, misalign, trap_epc);
        else pass_cnt++;
        do_fetch(32'hA);
        do_retire(1, 0, 0, 0, 32'h2, 32'h0);
        chk_cnt++; if (misalign !== 1'b1 || trap_epc !== 32'h1004 || pc !== 32'h100)
            $display("FAIL jal_trap: mis=%b epc=%h pc=%h required 1/00001004/00000100", misalign, trap_epc, pc);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
                $display("FAIL stall_hold_%0d: req=%b addr=%h required 1/00000100", i, imem_req, imem_addr);
            else pass_cnt++;
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk_cnt++; if (imem_req !== 1'b0) $display("FAIL stall_wait_req: got %b required 0", imem_req); else pass_cnt++;
        do_retire(1, 0, 0, 0, 32'h40, 32'h0);
        chk_cnt++; if (pc !== 32'h100 || instr_valid !== 1'b0)
            $display("FAIL retire_in_wait: pc=%h iv=%b required 00000100/0", pc, instr_valid);
        else pass_cnt++;
        imem_valid = 1'b1;
        imem_rdata = 32'hB;
        tick();
        imem_valid = 1'b0;
        chk_cnt++; if (instr_valid !== 1'b1 || instr !== 32'hB || pc !== 32'h100)
            $display("FAIL stall_exec: iv=%b instr=%h pc=%h required 1/0000000b/00000100", instr_valid, instr, pc);
        else pass_cnt++;
        do_retire(0, 0, 0, 0, 32'h0, 32'h0);
        chk_cnt++; if (pc !== 32'h104) $display("FAIL stall_next: pc=%h required 00000104", pc); else pass_cnt++;
    endtask

    task automatic test_wrap_priority();
        do_fetch(32'hC);
        do_retire(0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC);
        chk_cnt++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0)
            $display("FAIL top_pc: pc=%h pc4=%h required fffffffc/00000000", pc, pc_plus4);
        else pass_cnt++;
        do_fetch(32'hD);
        do_retire(0, 0, 0, 0, 32'h0, 32'h0);
        chk_cnt++; if (pc !== 32'h0 || misalign !== 1'b0)
            $display("FAIL wrap: pc=%h mis=%b required 00000000/0", pc, misalign);
        else pass_cnt++;
        do_fetch(32'hE);
        do_retire(1, 1, 1, 1, 32'h20, 32'h200);
        chk_cnt++; if (pc !== 32'h220) $display("FAIL jalr_priority: pc=%h required 00000220", pc); else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0)
            $display("FAIL async_reset: req=%b pc=%h iv=%b required 0/00000000/0", imem_req, pc, instr_valid);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        chk_cnt++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== 32'h0)
            $display("FAIL stale_valid: iv=%b req=%b pc=%h required 0/1/00000000", instr_valid, imem_req, pc);
        else pass_cnt++;
        imem_valid = 1'b0;
        do_fetch(32'h0000_00F0);
        chk_cnt++; if (instr_valid !== 1'b1 || instr !== 32'hF0 || pc !== 32'h0)
            $display("FAIL refetch: iv=%b instr=%h pc=%h required 1/000000f0/00000000", instr_valid, instr, pc);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jalr_trap();
        test_stall();
        test_wrap_priority();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
